// File: rtl/icache_if.sv
// Instruction-cache bus bundle: datapath request/response plus memory-controller fill port.
//   imemREN/imemaddr : datapath read request and byte address
//   ihit/imemload    : cache hit and returned instruction word
//   iREN/iaddr       : read request and word address to memory controller
//   iwait/iload      : memory controller stall and fill data
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  // Cache side
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  // Datapath / memory-controller side
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-entry, read-only instruction cache.
//   CLK, nRST : clock and asynchronous active-low reset
//   bus       : icache_if.slave (datapath request/response, memory fill port)
// Hits are answered combinationally in the request cycle; a miss moves to
// FETCH, which forwards the live request to memory until iwait drops.
module icache #(
  parameter int unsigned SETS = 16
) (
  input  logic     CLK,
  input  logic     nRST,
  icache_if.slave  bus
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 32 - IDX - 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t              state_q;
  logic [SETS-1:0]     valid_q;
  logic [TAGW-1:0]     tag_q  [SETS];
  logic [31:0]         data_q [SETS];

  logic [IDX-1:0]      idx_c;
  logic [TAGW-1:0]     tag_c;
  logic                hit_c;
  logic                fill_c;
  logic                unused_c;

  // Address split; byte offset is ignored
  assign idx_c    = bus.imemaddr[IDX+1:2];
  assign tag_c    = bus.imemaddr[31:IDX+2];
  assign unused_c = ^bus.imemaddr[1:0];

  // Lookup against the array as it stands this cycle, regardless of state
  assign hit_c  = bus.imemREN & valid_q[idx_c] & (tag_q[idx_c] == tag_c);

  // Fill uses whatever address is live in the cycle iwait falls
  assign fill_c = (state_q == FETCH) & bus.imemREN & ~bus.iwait;

  // Datapath and memory-side outputs
  assign bus.ihit     = hit_c;
  assign bus.imemload = hit_c ? data_q[idx_c] : 32'h0;
  assign bus.iREN     = (state_q == FETCH) & bus.imemREN;
  assign bus.iaddr    = (state_q == FETCH) ? {bus.imemaddr[31:2], 2'b00} : 32'h0;

  // State machine and cache array
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      valid_q <= '0;
      for (int i = 0; i < int'(SETS); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (state_q == IDLE) begin
        if (bus.imemREN && !hit_c) state_q <= FETCH;
      end else begin
        // Dropping the request aborts; otherwise leave once memory responds
        if (!bus.imemREN || !bus.iwait) state_q <= IDLE;
      end
      if (fill_c) begin
        valid_q[idx_c] <= 1'b1;
        tag_q[idx_c]   <= tag_c;
        data_q[idx_c]  <= bus.iload;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios push expected hits
// (cycle and data) into a scoreboard; a negedge monitor pops on every ihit.
module tb_icache;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned n_chk;
  int unsigned n_pass;
  exp_t        exp_q[$];

  icache_if bus();

  icache #(.SETS(16)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor: every ihit must match the oldest expected hit in cycle and data
  always @(negedge clk) begin
    exp_t e;
    if (bus.ihit === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_hit", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("hit_cycle", cyc, e.cyc);
        chk("hit_data", bus.imemload, e.data);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk("missing_hit", 32'd0, 32'd1);
    end
    if (bus.iREN === 1'b1) chk("iaddr_offset", {30'h0, bus.iaddr[1:0]}, 32'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss at address a, `waits` stall cycles, fill with d, hit the following cycle
  task automatic miss_fill(input logic [31:0] a, input logic [31:0] d, input int waits);
    step();
    bus.imemREN = 1'b1; bus.imemaddr = a; bus.iwait = 1'b1; bus.iload = 32'h0;
    #1 chk("miss_iren_idle", {31'h0, bus.iREN}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      step();
      bus.iwait = 1'b1;
      #1 chk("fetch_iren", {31'h0, bus.iREN}, 32'd1);
      chk("fetch_iaddr", bus.iaddr, {a[31:2], 2'b00});
    end
    step();
    bus.iwait = 1'b0; bus.iload = d;
    exp_q.push_back('{cyc: cyc + 1, data: d});
    #1 chk("fill_iren", {31'h0, bus.iREN}, 32'd1);
    chk("fill_iaddr", bus.iaddr, {a[31:2], 2'b00});
    step();
    bus.iwait = 1'b1; bus.iload = 32'h0;
    #1 chk("post_fill_iren", {31'h0, bus.iREN}, 32'd0);
  endtask

  // Same-cycle hit
  task automatic hit(input logic [31:0] a, input logic [31:0] d);
    step();
    bus.imemREN = 1'b1; bus.imemaddr = a; bus.iwait = 1'b1;
    exp_q.push_back('{cyc: cyc, data: d});
    #1 chk("hit_iren", {31'h0, bus.iREN}, 32'd0);
    chk("hit_iaddr", bus.iaddr, 32'h0);
  endtask

  // Request a that must miss, then abort back to IDLE
  task automatic expect_miss(input logic [31:0] a);
    step();
    bus.imemREN = 1'b1; bus.imemaddr = a; bus.iwait = 1'b1;
    #1 chk("miss_ihit", {31'h0, bus.ihit}, 32'd0);
    step();
    bus.imemREN = 1'b0;
    #1 chk("miss_abort_iren", {31'h0, bus.iREN}, 32'd0);
    step();
  endtask

  task automatic idle();
    step();
    bus.imemREN = 1'b0; bus.iwait = 1'b1; bus.iload = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.imemREN = 1'b1; bus.imemaddr = 32'h40; bus.iwait = 1'b0; bus.iload = 32'hFFFF_FFFF;
    #2;
    chk("rst_ihit", {31'h0, bus.ihit}, 32'd0);
    chk("rst_imemload", bus.imemload, 32'h0);
    chk("rst_iren", {31'h0, bus.iREN}, 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'h0);
    step(); step();
    bus.imemREN = 1'b0; bus.iwait = 1'b1;
    rst_n = 1'b1;

    // Cold miss with three stall cycles, then repeat hit
    miss_fill(32'h0000_0040, 32'h8C22_0004, 3);
    hit(32'h0000_0040, 32'h8C22_0004);
    idle();

    // Conflict eviction on index 0
    miss_fill(32'h0000_0440, 32'h1234_5678, 0);
    idle();
    miss_fill(32'h0000_0040, 32'hAAAA_0001, 1);
    // Byte offset ignored on lookup
    hit(32'h0000_0043, 32'hAAAA_0001);
    idle();

    // Abort: request dropped in FETCH (memory ready, but nothing written)
    step();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0088; bus.iwait = 1'b1;
    step();
    #1 chk("abort_fetch_iren", {31'h0, bus.iREN}, 32'd1);
    step();
    bus.imemREN = 1'b0; bus.iwait = 1'b0; bus.iload = 32'hDEAD_BEEF;
    #1 chk("abort_iren", {31'h0, bus.iREN}, 32'd0);
    step();
    bus.iwait = 1'b1;
    #1 chk("abort_idle_iaddr", bus.iaddr, 32'h0);
    miss_fill(32'h0000_0088, 32'h0BAD_F00D, 0);
    idle();

    // Address change during FETCH: fill goes to the address live when iwait falls
    step();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_000C; bus.iwait = 1'b1;
    step();
    #1 chk("chg_iaddr_old", bus.iaddr, 32'h0000_000C);
    step();
    bus.imemaddr = 32'h0000_0014; bus.iwait = 1'b0; bus.iload = 32'h5555_AAAA;
    exp_q.push_back('{cyc: cyc + 1, data: 32'h5555_AAAA});
    #1 chk("chg_iaddr_new", bus.iaddr, 32'h0000_0014);
    step();
    bus.iwait = 1'b1;
    idle();
    expect_miss(32'h0000_000C);

    // Unaligned miss address: word address on iaddr
    miss_fill(32'h0000_0203, 32'h0000_0077, 1);
    hit(32'h0000_0201, 32'h0000_0077);
    idle();

    // Reset in FETCH with memory ready
    step();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0308; bus.iwait = 1'b1;
    step();
    bus.iwait = 1'b0; bus.iload = 32'hCAFE_0001;
    #1 rst_n = 1'b0;
    bus.imemaddr = 32'h0000_0040;
    #1 chk("midrst_ihit", {31'h0, bus.ihit}, 32'd0);
    chk("midrst_imemload", bus.imemload, 32'h0);
    chk("midrst_iren", {31'h0, bus.iREN}, 32'd0);
    chk("midrst_iaddr", bus.iaddr, 32'h0);
    step();
    bus.imemREN = 1'b0; bus.iwait = 1'b1;
    rst_n = 1'b1;
    expect_miss(32'h0000_0040);
    expect_miss(32'h0000_0203);
    miss_fill(32'h0000_0308, 32'hCAFE_0002, 0);
    idle();

    step(); step();
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
